// File: rtl/wb_stage_if.sv
// wb_stage_if: bundles the MEM-to-WB capture inputs and the register-file
// write port produced by the write-back stage.
//   master: the side that drives the MEM-stage fields and consumes the RF port
//   slave : the write-back stage itself
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            m_valid;
    logic            m_RFWrite;
    logic [4:0]      m_rd;
    logic [1:0]      m_WDSel;
    logic [2:0]      m_DMType;
    logic [XLEN-1:0] m_alu_out;
    logic [XLEN-1:0] m_dmem_rdata;
    logic [XLEN-1:0] m_pc;

    logic            RFWrite;
    logic [4:0]      addr3;
    logic [XLEN-1:0] data_in;
    logic            w_valid;

    modport master (
        output m_valid, m_RFWrite, m_rd, m_WDSel, m_DMType,
               m_alu_out, m_dmem_rdata, m_pc,
        input  RFWrite, addr3, data_in, w_valid
    );

    modport slave (
        input  m_valid, m_RFWrite, m_rd, m_WDSel, m_DMType,
               m_alu_out, m_dmem_rdata, m_pc,
        output RFWrite, addr3, data_in, w_valid
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus write-back data selection.
// Captures the memory-stage result each rising edge, extracts/extends load
// data, and drives the register-file write port (RFWrite/addr3/data_in).
// All outputs depend only on registered state.
// Optional feature: define WB_RETIRE_CNT_EN to build the 32-bit retired
// instruction counter and its retire_cnt output port.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    wb_stage_if.slave   wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    logic            valid_q,   valid_d;
    logic            rfwrite_q, rfwrite_d;
    logic [4:0]      rd_q,      rd_d;
    logic [1:0]      wdsel_q,   wdsel_d;
    logic [2:0]      dmtype_q,  dmtype_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] rdata_q,   rdata_d;
    logic [XLEN-1:0] pc_q,      pc_d;

    logic [1:0]      off;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wdata;

    // Next WB register contents: flush kills the instruction (fields hold), stall holds all.
    always_comb begin
        valid_d   = valid_q;
        rfwrite_d = rfwrite_q;
        rd_d      = rd_q;
        wdsel_d   = wdsel_q;
        dmtype_d  = dmtype_q;
        alu_out_d = alu_out_q;
        rdata_d   = rdata_q;
        pc_d      = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d   = wb.m_valid;
            rfwrite_d = wb.m_RFWrite;
            rd_d      = wb.m_rd;
            wdsel_d   = wb.m_WDSel;
            dmtype_d  = wb.m_DMType;
            alu_out_d = wb.m_alu_out;
            rdata_d   = wb.m_dmem_rdata;
            pc_d      = wb.m_pc;
        end
    end

    // WB pipeline register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rfwrite_q <= 1'b0;
            rd_q      <= '0;
            wdsel_q   <= '0;
            dmtype_q  <= '0;
            alu_out_q <= '0;
            rdata_q   <= '0;
            pc_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            rfwrite_q <= rfwrite_d;
            rd_q      <= rd_d;
            wdsel_q   <= wdsel_d;
            dmtype_q  <= dmtype_d;
            alu_out_q <= alu_out_d;
            rdata_q   <= rdata_d;
            pc_q      <= pc_d;
        end
    end

    // Pick the addressed byte/halfword out of the aligned word and extend it.
    always_comb begin
        off = alu_out_q[1:0];
        case (off)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (dmtype_q)
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            3'b011:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            default: load_data = rdata_q;
        endcase
    end

    // Write-data source select; the reserved encoding writes zero.
    always_comb begin
        case (wdsel_q)
            2'd0:    wdata = alu_out_q;
            2'd1:    wdata = load_data;
            2'd2:    wdata = pc_q + XLEN'(4);
            default: wdata = '0;
        endcase
    end

    assign wb.RFWrite = valid_q & rfwrite_q & (rd_q != 5'd0);
    assign wb.addr3   = rd_q;
    assign wb.data_in = wdata;
    assign wb.w_valid = valid_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // An instruction retires when it leaves the WB register, i.e. valid and not held.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q && !stall) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Retire counter register, cleared by reset, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage. Table-driven vectors,
// hand-written stall/flush/reset/RF sequences and a randomized run checked
// against an arithmetic reference model. Counter checks are built only
// when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    wb_stage_if #(.XLEN(32)) bus ();

    wb_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .wb    (bus)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small register file that commits on the falling edge.
    logic [31:0] rf [32];
    always @(negedge clk) begin
        if (bus.RFWrite === 1'b1) rf[bus.addr3] = bus.data_in;
    end

    // Reference model state: the instruction currently held in WB.
    logic        mdl_valid;
    logic        mdl_rfwrite;
    logic [4:0]  mdl_rd;
    logic [1:0]  mdl_wdsel;
    logic [2:0]  mdl_dmtype;
    logic [31:0] mdl_alu;
    logic [31:0] mdl_rdata;
    logic [31:0] mdl_pc;
    bit          mdl_known;
    logic [31:0] mdl_cnt;

    function automatic logic [31:0] model_data(input logic [1:0] wdsel, input logic [2:0] dmt,
                                               input logic [31:0] alu, input logic [31:0] rdata,
                                               input logic [31:0] pc);
        int unsigned off = alu % 4;
        logic [31:0] b = (rdata >> (8 * off)) & 32'hFF;
        logic [31:0] h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        logic [31:0] ld;
        case (dmt)
            3'd3:    ld = (b >= 32'd128)   ? b + 32'hFFFFFF00 : b;
            3'd4:    ld = b;
            3'd1:    ld = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'd2:    ld = h;
            default: ld = rdata;
        endcase
        case (wdsel)
            2'd0:    return alu;
            2'd1:    return ld;
            2'd2:    return pc + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check({name, ".w_valid"}, {31'd0, bus.w_valid}, {31'd0, mdl_valid});
        check({name, ".RFWrite"}, {31'd0, bus.RFWrite},
              {31'd0, mdl_valid & mdl_rfwrite & (mdl_rd != 5'd0)});
        if (mdl_known) begin
            check({name, ".addr3"}, {27'd0, bus.addr3}, {27'd0, mdl_rd});
            check({name, ".data_in"}, bus.data_in,
                  model_data(mdl_wdsel, mdl_dmtype, mdl_alu, bus.m_dmem_rdata === 32'hx ? mdl_rdata : mdl_rdata, mdl_pc));
        end
`ifdef WB_RETIRE_CNT_EN
        check({name, ".retire_cnt"}, retire_cnt, mdl_cnt);
`endif
    endtask

    // One clock: advance the model from the current inputs, then sample #1 after the edge.
    task automatic cycle(input string name);
        if (!rst_n) begin
            mdl_valid = 0; mdl_rfwrite = 0; mdl_rd = 0; mdl_wdsel = 0; mdl_dmtype = 0;
            mdl_alu = 0; mdl_rdata = 0; mdl_pc = 0; mdl_known = 1; mdl_cnt = 0;
        end else begin
            if (mdl_valid && !stall) mdl_cnt = mdl_cnt + 32'd1;
            if (flush) begin
                mdl_valid = 0;
                mdl_known = 0;
            end else if (!stall) begin
                mdl_valid   = bus.m_valid;
                mdl_rfwrite = bus.m_RFWrite;
                mdl_rd      = bus.m_rd;
                mdl_wdsel   = bus.m_WDSel;
                mdl_dmtype  = bus.m_DMType;
                mdl_alu     = bus.m_alu_out;
                mdl_rdata   = bus.m_dmem_rdata;
                mdl_pc      = bus.m_pc;
                mdl_known   = 1;
            end
        end
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    task automatic apply_stimulus(input logic v, input logic w, input logic [4:0] rd,
                                  input logic [1:0] sel, input logic [2:0] dmt,
                                  input logic [31:0] alu, input logic [31:0] rdata,
                                  input logic [31:0] pc);
        bus.m_valid = v; bus.m_RFWrite = w; bus.m_rd = rd; bus.m_WDSel = sel;
        bus.m_DMType = dmt; bus.m_alu_out = alu; bus.m_dmem_rdata = rdata; bus.m_pc = pc;
    endtask

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic        v;
        logic        w;
        logic [1:0]  sel;
        logic [2:0]  dmt;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{"lb_off2",    5'd1, 1, 1, 2'd1, 3'b011, 32'h00001002, 32'h80FF7F01, 32'h0, 1, 32'hFFFFFFFF};
        vecs[1]  = '{"lbu_off3",   5'd2, 1, 1, 2'd1, 3'b100, 32'h00001003, 32'h80FF7F01, 32'h0, 1, 32'h00000080};
        vecs[2]  = '{"lh_off2",    5'd3, 1, 1, 2'd1, 3'b001, 32'h00001002, 32'h80FF7F01, 32'h0, 1, 32'hFFFF80FF};
        vecs[3]  = '{"lhu_off1",   5'd4, 1, 1, 2'd1, 3'b010, 32'h00001001, 32'h80FF7F01, 32'h0, 1, 32'h00007F01};
        vecs[4]  = '{"lw_off3",    5'd5, 1, 1, 2'd1, 3'b000, 32'h00001003, 32'h80FF7F01, 32'h0, 1, 32'h80FF7F01};
        vecs[5]  = '{"lb_off1",    5'd6, 1, 1, 2'd1, 3'b011, 32'h00001001, 32'h80FF7F01, 32'h0, 1, 32'h0000007F};
        vecs[6]  = '{"lh_off0",    5'd7, 1, 1, 2'd1, 3'b001, 32'h00001000, 32'h80FF7F01, 32'h0, 1, 32'h00007F01};
        vecs[7]  = '{"dmt7_as_lw", 5'd8, 1, 1, 2'd1, 3'b111, 32'h00001001, 32'h80FF7F01, 32'h0, 1, 32'h80FF7F01};
        vecs[8]  = '{"jal",        5'd1, 1, 1, 2'd2, 3'b000, 32'h0, 32'h0, 32'h00400010, 1, 32'h00400014};
        vecs[9]  = '{"jal_wrap",   5'd1, 1, 1, 2'd2, 3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 1, 32'h00000000};
        vecs[10] = '{"jal_x0",     5'd0, 1, 1, 2'd2, 3'b000, 32'h0, 32'h0, 32'h00000100, 0, 32'h00000104};
        vecs[11] = '{"wdsel3",     5'd9, 1, 1, 2'd3, 3'b000, 32'h5555AAAA, 32'h0, 32'h10, 1, 32'h00000000};
        vecs[12] = '{"bubble",     5'd9, 0, 1, 2'd0, 3'b000, 32'h00000042, 32'h0, 32'h10, 0, 32'h00000042};
    end

    initial begin
        logic [31:0] cnt_start;
        rst_n = 0; stall = 0; flush = 0;
        mdl_valid = 0; mdl_rfwrite = 0; mdl_rd = 0; mdl_wdsel = 0; mdl_dmtype = 0;
        mdl_alu = 0; mdl_rdata = 0; mdl_pc = 0; mdl_known = 0; mdl_cnt = 0;
        apply_stimulus(1, 1, 5'd9, 2'd0, 3'd0, 32'hFFFF, 32'h0, 32'h0);
        #2;

        // Reset held for two cycles with a live instruction on the inputs.
        cycle("reset1");
        cycle("reset2");
        check("reset.RFWrite", {31'd0, bus.RFWrite}, 32'd0);
        check("reset.addr3", {27'd0, bus.addr3}, 32'd0);
        check("reset.data_in", bus.data_in, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check("reset.retire_cnt", retire_cnt, 32'd0);
`endif

        rst_n = 1;
        apply_stimulus(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
        cycle("release");
        check("release.RFWrite", {31'd0, bus.RFWrite}, 32'd1);
        check("release.addr3", {27'd0, bus.addr3}, 32'd5);
        check("release.data_in", bus.data_in, 32'h1234);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].v, vecs[i].w, vecs[i].rd, vecs[i].sel, vecs[i].dmt,
                           vecs[i].alu, vecs[i].rdata, vecs[i].pc);
            cycle(vecs[i].name);
            check({vecs[i].name, ".tbl_we"}, {31'd0, bus.RFWrite}, {31'd0, vecs[i].exp_we});
            check({vecs[i].name, ".tbl_data"}, bus.data_in, vecs[i].exp_data);
        end

        // Stall: instruction A held for three stalled cycles while inputs change.
        apply_stimulus(1, 1, 5'd10, 2'd0, 3'd0, 32'hA5A5A5A5, 32'h0, 32'h0);
        cycle("stall_load");
        cnt_start = mdl_cnt;
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 1, 5'(11 + k), 2'd0, 3'd0, 32'h1111 * (k + 2), 32'h0, 32'h0);
            cycle("stall_hold");
            check("stall.addr3", {27'd0, bus.addr3}, 32'd10);
            check("stall.data_in", bus.data_in, 32'hA5A5A5A5);
            check("stall.RFWrite", {31'd0, bus.RFWrite}, 32'd1);
        end
        stall = 0;
        apply_stimulus(1, 1, 5'd12, 2'd0, 3'd0, 32'h0BADF00D, 32'h0, 32'h0);
        cycle("stall_release");
        check("stall_release.data_in", bus.data_in, 32'h0BADF00D);
`ifdef WB_RETIRE_CNT_EN
        check("stall.retire_once", retire_cnt - cnt_start, 32'd1);
`endif

        // Flush together with stall: flush wins.
        stall = 1; flush = 1;
        cycle("flush_stall");
        check("flush_stall.w_valid", {31'd0, bus.w_valid}, 32'd0);
        check("flush_stall.RFWrite", {31'd0, bus.RFWrite}, 32'd0);
        stall = 0; flush = 0;

        // Back-to-back write then decode read of x7 across the falling edge.
        apply_stimulus(1, 1, 5'd7, 2'd0, 3'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        cycle("rf_write_x7");
        @(negedge clk);
        #1;
        check("rf_read_x7", rf[7], 32'hDEADBEEF);

        // Randomized run against the model, including occasional resets.
        for (int n = 0; n < 300; n++) begin
            apply_stimulus(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
                           3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 10);
            rst_n = ($urandom_range(0, 99) >= 3);
            cycle("random");
        end
        rst_n = 1; stall = 0; flush = 0;

`ifdef WB_RETIRE_CNT_EN
        // Counter wrap from all-ones.
        apply_stimulus(1, 1, 5'd3, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0);
        cycle("wrap_load");
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        mdl_cnt = 32'hFFFFFFFF;
        apply_stimulus(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        cycle("wrap_retire");
        check("wrap.retire_cnt", retire_cnt, 32'd0);

        // Ten retires interleaved with four bubbles.
        cycle("bubble_pre");
        cnt_start = retire_cnt;
        for (int k = 0; k < 14; k++) begin
            apply_stimulus((k % 7) >= 2, 1, 5'd4, 2'd0, 3'd0, 32'(k), 32'h0, 32'h0);
            cycle("interleave");
        end
        apply_stimulus(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        cycle("interleave_drain");
        check("interleave.retire_delta", retire_cnt - cnt_start, 32'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and write-back selector of the five-stage pipeline. It captures the memory-stage result on each rising clock edge, then forms the register-file write port from that result: write enable, destination index and write data. Load data is extracted and extended here. The register file commits on the following falling edge, so a write-back and a decode read of the same register resolve within one cycle.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `stall` in 1: hold the WB register contents.
- `flush` in 1: load a bubble into the WB register.
- `m_valid` in 1: the MEM stage holds a real instruction.
- `m_RFWrite` in 1: the instruction writes a register.
- `m_rd` in 5: destination register index.
- `m_WDSel` in 2: write-data source. 0 = ALU result, 1 = load data, 2 = PC+4, 3 = reserved.
- `m_DMType` in 3: load type. 000 = lw, 001 = lh, 010 = lhu, 011 = lb, 100 = lbu; any other value behaves as lw.
- `m_alu_out` in XLEN: ALU result. For loads this is the effective address.
- `m_dmem_rdata` in XLEN: raw aligned data-memory word.
- `m_pc` in XLEN: PC of the instruction.
- `RFWrite` out 1: register-file write enable.
- `addr3` out 5: register-file write index.
- `data_in` out XLEN: register-file write data. `addr3` and `data_in` also serve as the WB forwarding source.
- `w_valid` out 1: the WB register holds a real instruction.
- `retire_cnt` out 32: retired-instruction count. Present only with `WB_RETIRE_CNT_EN`.

## Operation
- The WB register holds: `valid`, `rfwrite`, `rd`, `wdsel`, `dmtype`, `alu_out`, `rdata` and `pc`.
- Update priority on each rising edge:
  - `!rst_n`: all fields are cleared to 0.
  - Otherwise, if `flush`: `valid` = 0. The other fields may load or hold.
  - Otherwise, if `stall`: all fields hold.
  - Otherwise: all fields load from the `m_*` inputs.
- Load extraction uses offset `off` = `alu_out[1:0]`:
  - lb/lbu select byte `rdata[8*off+7 : 8*off]`. lb sign-extends; lbu zero-extends.
  - lh/lhu select the halfword `rdata[16*off[1]+15 : 16*off[1]]`; `off[0]` is ignored. lh sign-extends; lhu zero-extends.
  - lw passes `rdata` through unchanged and ignores `off`.
- Write-data mux (combinational from the registered fields):
  - `wdsel` = 0: `alu_out`.
  - `wdsel` = 1: extracted load data.
  - `wdsel` = 2: `pc + 4`, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - `wdsel` = 3: 0.
- `RFWrite` = `valid & rfwrite & (rd != 0)`. x0 is never written, and `RFWrite` is 0 for bubbles.
- `addr3` = `rd` and `data_in` = mux result, driven even when `RFWrite` = 0.
- During `stall`, `RFWrite` stays asserted for the held instruction. The repeated write of the same value is idempotent and is permitted.
- `flush` and `stall` asserted together: `flush` wins.

## Timing
- Latency: the `m_*` inputs sampled at edge N appear on the outputs after edge N. The RF commits at the falling edge in the middle of cycle N+1. Total: 1.5 cycles from MEM capture to register-file state.
- All outputs are combinational from registered state only. There is no input-to-output combinational path.
- Reset values: `w_valid` = 0, `RFWrite` = 0, `addr3` = 0, `data_in` = 0 (`wdsel` 0, `alu_out` 0), `retire_cnt` = 0.
- Reset applied mid-stream clears state at the next rising edge, regardless of `stall` or `flush`. Any instruction held in the WB register is discarded and never counted.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - A 32-bit `retire_cnt` register and its output port are built.
  - It increments by 1 at each rising edge where `rst_n` = 1, `w_valid` = 1 and `stall` = 0. A held instruction counts exactly once.
  - It wraps from 0xFFFFFFFF to 0.
  - It is cleared by reset and is unaffected by `flush`.
- `WB_RETIRE_CNT_EN` undefined: no counter logic and no `retire_cnt` port. All other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `m_valid` = 1 and `m_RFWrite` = 1 -> `RFWrite` = 0, `addr3` = 0, `data_in` = 0, `retire_cnt` = 0. Release with an ALU op, `rd` = 5, `alu_out` = 0x1234 -> after one edge, `RFWrite` = 1, `addr3` = 5, `data_in` = 0x1234.
- Loads with `rdata` = 0x80FF7F01:
  - lb, off = 2 -> 0xFFFFFFFF.
  - lbu, off = 3 -> 0x00000080.
  - lh, off = 2 -> 0xFFFF80FF.
  - lhu, off = 1 -> 0x00007F01.
  - lw, off = 3 -> 0x80FF7F01.
- JAL-style write: `wdsel` = 2 with `pc` = 0x00400010 -> 0x00400014. With `pc` = 0xFFFFFFFC -> 0. With `rd` = 0 -> `RFWrite` = 0 and `data_in` = `pc` + 4.
- Stall: load instruction A, then assert `stall` for 3 cycles while changing the inputs -> outputs hold A for the 3 stalled cycles (4 cycles total) and `retire_cnt` advances by 1. With `flush` and `stall` both asserted -> `w_valid` = 0 and `RFWrite` = 0 on the next cycle.
- Back-to-back write/read: WB writes x7 = 0xDEADBEEF while decode reads x7 in the same cycle -> the register-file read after the falling edge returns 0xDEADBEEF.
- Counter wrap (`WB_RETIRE_CNT_EN`): force the count to 0xFFFFFFFF, then retire one valid instruction -> 0. Retire 10 instructions interleaved with 4 bubbles -> increment of exactly 10.
